// File: rtl/fp_wb_scoreboard.sv
// Purpose: FP register-file write-port owner. It merges fast FPU and slow FDIV/FSQRT results and tracks pending destinations for RAW/WAW hazard checks.
// Latency: a result accepted in cycle N is written on rf_we/rf_wa/rf_wd in cycle N+1. A slow result passes through the queue, so it is written no earlier than N+2.
// Backpressure: the fast path cannot be stalled. The slow path uses valid/ready (slow_ready = queue not full). Issue is held by issue_ready.
//
// Ports:
//   clk, rst_n                    clock and asynchronous active-low reset
//   issue_*                       FP instruction at issue; issue_ready is combinational
//   fast_valid/rd/data            pipelined FPU result; always wins the write port
//   slow_valid/rd/data/ready      div/sqrt result into the holding queue
//   rf_we/wa/wd                   registered register-file write port
//   busy                          pending-write bitmap
// Optional feature macro FP_WB_FFLAGS_EN adds the following ports:
//   fast_flags, slow_flags, flags_clr, fflags (sticky exception flags).

module fp_wb_scoreboard #(
   parameter int NREG     = 32,
   parameter int DW       = 32,
   parameter int SQ_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            issue_valid,
   input  logic [4:0]      issue_rd,
   input  logic [4:0]      issue_rs1,
   input  logic [4:0]      issue_rs2,
   input  logic [4:0]      issue_rs3,
   input  logic            issue_use3,
   output logic            issue_ready,
   input  logic            fast_valid,
   input  logic [4:0]      fast_rd,
   input  logic [DW-1:0]   fast_data,
   input  logic            slow_valid,
   input  logic [4:0]      slow_rd,
   input  logic [DW-1:0]   slow_data,
   output logic            slow_ready,
`ifdef FP_WB_FFLAGS_EN
   input  logic [4:0]      fast_flags,
   input  logic [4:0]      slow_flags,
   input  logic            flags_clr,
   output logic [4:0]      fflags,
`endif
   output logic            rf_we,
   output logic [4:0]      rf_wa,
   output logic [DW-1:0]   rf_wd,
   output logic [NREG-1:0] busy
);

   localparam int PW = (SQ_DEPTH > 1) ? $clog2(SQ_DEPTH) : 1;

   // Write port registers
   logic            rf_we_q, rf_we_d;
   logic [4:0]      rf_wa_q, rf_wa_d;
   logic [DW-1:0]   rf_wd_q, rf_wd_d;

   // Pending-write bitmap
   logic [NREG-1:0] busy_q, busy_d;

   // Slow-result holding queue
   logic [DW-1:0]   sq_data_q [SQ_DEPTH];
   logic [DW-1:0]   sq_data_d [SQ_DEPTH];
   logic [4:0]      sq_rd_q   [SQ_DEPTH];
   logic [4:0]      sq_rd_d   [SQ_DEPTH];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PW:0]     cnt_q, cnt_d;

`ifdef FP_WB_FFLAGS_EN
   logic [4:0]      sq_flags_q [SQ_DEPTH];
   logic [4:0]      sq_flags_d [SQ_DEPTH];
   logic [4:0]      rf_flags_q, rf_flags_d;
   logic [4:0]      fflags_q, fflags_d;
`endif

   logic            sq_full;
   logic            sq_empty;
   logic            push;
   logic            pop;
   logic            fire;
   logic [NREG-1:0] clr_mask;
   logic [NREG-1:0] set_mask;
   logic [NREG-1:0] eff_busy;

   // Hazard view and issue handshake
   always_comb begin
      // The register being written this cycle is bypassed by the register file,
      // so it no longer counts as a hazard.
      clr_mask = '0;
      if (rf_we_q) begin
         clr_mask = NREG'(1) << rf_wa_q;
      end
      eff_busy = busy_q & ~clr_mask;

      issue_ready = !eff_busy[issue_rs1] && !eff_busy[issue_rs2] &&
                    !(issue_use3 && eff_busy[issue_rs3]) &&
                    !eff_busy[issue_rd];
      fire = issue_valid && issue_ready;

      set_mask = '0;
      if (fire) begin
         set_mask = NREG'(1) << issue_rd;
      end
      // Set is applied after clear, so a re-issue to the register being retired stays busy.
      busy_d = (busy_q & ~clr_mask) | set_mask;
   end

   // Queue control
   always_comb begin
      sq_full    = (cnt_q == (PW+1)'(SQ_DEPTH));
      sq_empty   = (cnt_q == '0);
      slow_ready = !sq_full;
      push       = slow_valid && slow_ready;
      // The queue only gets the port when the fast path is idle.
      pop        = !fast_valid && !sq_empty;

      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      sq_data_d = sq_data_q;
      sq_rd_d   = sq_rd_q;
`ifdef FP_WB_FFLAGS_EN
      sq_flags_d = sq_flags_q;
`endif

      if (push) begin
         sq_data_d[wr_ptr_q] = slow_data;
         sq_rd_d[wr_ptr_q]   = slow_rd;
`ifdef FP_WB_FFLAGS_EN
         sq_flags_d[wr_ptr_q] = slow_flags;
`endif
         // SQ_DEPTH is a power of two, so the natural overflow wraps the pointer.
         wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end

      case ({push, pop})
         2'b10:   cnt_d = cnt_q + (PW+1)'(1);
         2'b01:   cnt_d = cnt_q - (PW+1)'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // Write-port arbitration: fast first, then the queue head
   always_comb begin
      rf_we_d = 1'b0;
      rf_wa_d = rf_wa_q;
      rf_wd_d = rf_wd_q;
`ifdef FP_WB_FFLAGS_EN
      rf_flags_d = 5'd0;
`endif
      if (fast_valid) begin
         rf_we_d = 1'b1;
         rf_wa_d = fast_rd;
         rf_wd_d = fast_data;
`ifdef FP_WB_FFLAGS_EN
         rf_flags_d = fast_flags;
`endif
      end else if (pop) begin
         rf_we_d = 1'b1;
         rf_wa_d = sq_rd_q[rd_ptr_q];
         rf_wd_d = sq_data_q[rd_ptr_q];
`ifdef FP_WB_FFLAGS_EN
         rf_flags_d = sq_flags_q[rd_ptr_q];
`endif
      end
   end

`ifdef FP_WB_FFLAGS_EN
   // Sticky flags: the OR from this cycle's write survives a simultaneous clear.
   always_comb begin
      fflags_d = flags_clr ? 5'd0 : fflags_q;
      if (rf_we_q) begin
         fflags_d = fflags_d | rf_flags_q;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf_we_q  <= 1'b0;
         rf_wa_q  <= '0;
         rf_wd_q  <= '0;
         busy_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         for (int i = 0; i < SQ_DEPTH; i++) begin
            sq_data_q[i] <= '0;
            sq_rd_q[i]   <= '0;
`ifdef FP_WB_FFLAGS_EN
            sq_flags_q[i] <= '0;
`endif
         end
`ifdef FP_WB_FFLAGS_EN
         rf_flags_q <= '0;
         fflags_q   <= '0;
`endif
      end else begin
         rf_we_q   <= rf_we_d;
         rf_wa_q   <= rf_wa_d;
         rf_wd_q   <= rf_wd_d;
         busy_q    <= busy_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         cnt_q     <= cnt_d;
         sq_data_q <= sq_data_d;
         sq_rd_q   <= sq_rd_d;
`ifdef FP_WB_FFLAGS_EN
         sq_flags_q <= sq_flags_d;
         rf_flags_q <= rf_flags_d;
         fflags_q   <= fflags_d;
`endif
      end
   end

   assign rf_we = rf_we_q;
   assign rf_wa = rf_wa_q;
   assign rf_wd = rf_wd_q;
   assign busy  = busy_q;
`ifdef FP_WB_FFLAGS_EN
   assign fflags = fflags_q;
`endif

endmodule
